// File: rtl/sprite_drawer_if.sv
// Sprite drawer bus: start/base request, sprite RAM read port, VGA pixel port and status.
interface sprite_drawer_if;
  logic        start;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport slave (
    input  start, base_x, base_y, ram_data,
    output ram_addr, vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport master (
    output start, base_x, base_y, ram_data,
    input  ram_addr, vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_drawer.sv
// Walks a sprite record list from RAM and plots each opaque, on-screen pixel at a
// base offset; the walk stops at the first invalid record or at the end of RAM.
module sprite_drawer #(
  parameter int         MAX_WORDS   = 800,
  parameter logic [2:0] TRANSPARENT = 3'b000,
  parameter int         X_LIMIT     = 160,
  parameter int         Y_LIMIT     = 120
) (
  input  logic            clk,
  input  logic            resetn,
  sprite_drawer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EVAL, FINISH} state_t;

  localparam logic [9:0] LAST_ADDR = 10'(MAX_WORDS - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_base_x, w_base_x_nxt;
  logic [6:0]  r_base_y, w_base_y_nxt;
  logic [9:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_vga_x, w_vga_x_nxt;
  logic [6:0]  r_vga_y, w_vga_y_nxt;
  logic [2:0]  r_colour, w_colour_nxt;
  logic        r_plot, w_plot_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;

  logic [5:0]  w_rec_x, w_rec_y;
  logic [2:0]  w_rec_c;
  logic        w_valid, w_last, w_draw, w_stop;
  logic [8:0]  w_sx, w_sy;

  assign w_rec_x = bus.ram_data[15:10];
  assign w_rec_y = bus.ram_data[9:4];
  assign w_rec_c = bus.ram_data[3:1];
  assign w_valid = bus.ram_data[0];
  // 9-bit sums so an off-screen sprite never wraps back onto the screen
  assign w_sx    = {1'b0, r_base_x} + {3'b0, w_rec_x};
  assign w_sy    = {2'b0, r_base_y} + {3'b0, w_rec_y};
  assign w_last  = (r_addr == LAST_ADDR);
  assign w_draw  = w_valid && (w_rec_c != TRANSPARENT) &&
                   (w_sx < 9'(X_LIMIT)) && (w_sy < 9'(Y_LIMIT));
  assign w_stop  = !w_valid || w_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_base_x <= '0;
      r_base_y <= '0;
      r_addr   <= '0;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_base_x <= w_base_x_nxt;
      r_base_y <= w_base_y_nxt;
      r_addr   <= w_addr_nxt;
      r_vga_x  <= w_vga_x_nxt;
      r_vga_y  <= w_vga_y_nxt;
      r_colour <= w_colour_nxt;
      r_plot   <= w_plot_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = EVAL;
      EVAL:    w_state_nxt = w_stop ? FINISH : FETCH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_base_x_nxt = r_base_x;
    w_base_y_nxt = r_base_y;
    w_addr_nxt   = r_addr;
    w_vga_x_nxt  = r_vga_x;
    w_vga_y_nxt  = r_vga_y;
    w_colour_nxt = r_colour;
    w_plot_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_base_x_nxt = bus.base_x;
        w_base_y_nxt = bus.base_y;
        w_addr_nxt   = '0;
        w_busy_nxt   = 1'b1;
      end
      EVAL: begin
        if (w_draw) begin
          w_vga_x_nxt  = w_sx[7:0];
          w_vga_y_nxt  = w_sy[6:0];
          w_colour_nxt = w_rec_c;
          w_plot_nxt   = 1'b1;
        end
        if (w_stop) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else begin
          w_addr_nxt = r_addr + 10'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.ram_addr   = r_addr;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_colour;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
